paddle_cmd_queue: RTL and testbench
===================================

# paddle_cmd_queue

Upstream stage between the Nios custom-instruction port and the two paddle renderers. Captures paddle-position commands written through the custom instruction and buffers them in a small FIFO. Drains them only at frame boundaries, clamps and slew-limits each paddle's Y, and drives per-paddle position plus one-cycle refresh pulses. The renderers therefore never see a position change mid-frame.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `Y_MAX`, 420: highest legal paddle top Y (480 minus paddle height 60).
- `Y_RESET`, 210: paddle Y after reset.
- `STEP_MAX`, 8: maximum Y change per paddle per frame (slew option only).

- `CLK` in 1: board clock; all logic on its rising edge.
- `resentinho` in 1: reset, asynchronous, active-low.
- `CLK_EN` in 1: custom-instruction enable level from the CPU. Sampled in `CLK`; a command is its 0→1 transition.
- `dataa` in 32: command word. [9]=1 selects bar 1, [9]=0 selects bar 2; [8:0] is target Y; [31:10] are ignored.
- `enable_game` in 1: game running.
- `frame_start` in 1: one-`CLK` pulse at start of vertical blanking.
- `y_bar1`, `y_bar2` out 9: current paddle Y.
- `refresh_bar1`, `refresh_bar2` out 1: one-cycle pulse in the cycle the matching `y_barN` takes a new value.
- `status` out 32: [7:0] FIFO level, [15:8] drop count, [31:16] zero.

## Operation
- Edge detect:
  - `en_q` registers `CLK_EN`.
  - Push request = `CLK_EN & ~en_q`.
  - The entry stored is {dataa[9], clamp(dataa[8:0])}, where clamp = min(value, `Y_MAX`).
- Push rules:
  - Accepted if `enable_game`=1 and FIFO not full.
  - A push at full is accepted only in the same cycle as a pop.
  - Otherwise the command is dropped. The drop counter increments and saturates at 255.
- `enable_game`=0:
  - FIFO level is forced to 0 each cycle.
  - Requests are discarded and not counted.
  - Targets and outputs hold.
- Per-paddle target registers `t1` and `t2` reset to `Y_RESET`.
- FSM:
  - IDLE: FIFO empty. → WAIT when the level becomes nonzero.
  - WAIT: on `frame_start`=1 → DRAIN.
  - DRAIN: pop one entry per cycle and write its Y to the selected target, so the last write to a bar wins. → SLEW in the cycle after the pop that empties the FIFO. Entries pushed during DRAIN are drained in the same pass.
  - SLEW: single cycle. Each paddle whose `y_barN` differs from `tN` updates and pulses `refresh_barN`. Both paddles may pulse together. → WAIT if the FIFO is nonempty, else IDLE.
- `frame_start` is ignored outside WAIT.
- If `enable_game` falls during DRAIN, the FSM goes to SLEW next cycle with the targets written so far.
- Arithmetic:
  - Differences are computed as 10-bit signed values.
  - Outputs never exceed `Y_MAX` and never underflow 0.

## Timing
- Reset values: `y_bar1` = `y_bar2` = `Y_RESET`; `refresh_bar1` = `refresh_bar2` = 0; `status` = 0; FSM in IDLE; `en_q` = 0.
- `CLK_EN` rising in cycle N: entry is written at the end of N and visible in `status` at N+1.
- `frame_start` in cycle F with k entries queued:
  - DRAIN occupies cycles F+1..F+k.
  - SLEW occupies F+k+1.
  - New `y_barN` and the refresh pulse are visible in F+k+2.
- Reset asserted mid-operation clears everything immediately.
- The first command after reset release needs a fresh `CLK_EN` rising edge. `CLK_EN` held high through reset release does not count as a command.

## Configuration
- `PADDLE_SLEW_EN` defined: SLEW moves `y_barN` toward `tN` by min(|tN − y_barN|, `STEP_MAX`). A paddle not yet at its target keeps pulsing once per frame. To do this, the FSM enters WAIT→DRAIN→SLEW on `frame_start` even with an empty FIFO (zero pops) while any `y_barN` ≠ `tN`.
- Not defined: SLEW copies `tN` directly into `y_barN`, and `STEP_MAX` is unused.

## Test plan
- Reset: `resentinho`=0 → `y_bar1` = `y_bar2` = 210, refreshes 0, `status` = 0. Release, then `CLK_EN` held high → no push.
- Single command, slew off: `enable_game`=1, `dataa`=0x264 (bar1, Y=100), `frame_start` 10 cycles later → `y_bar1`=100 with a single `refresh_bar1` pulse at F+3. `y_bar2` stays 210.
- Clamp and coalesce: bar2 Y=500, then bar2 Y=300, then `frame_start` → `y_bar2`=300 in one update. A lone bar2 Y=511 gives `y_bar2`=420.
- Overflow: 6 commands with no `frame_start`, DEPTH=4 → `status`[7:0]=4, `status`[15:8]=2. After 300 more drops, `status`[15:8]=255.
- Slew on: bar1 target 0 from 210 → `y_bar1` reads 202, 194, … per `frame_start`, reaching 0 after 27 frames with one pulse per frame. Pulses stop once Y=0.
- Game disable: `enable_game`=0 with 3 queued entries → level 0 next cycle, no further updates, drop count unchanged.

Source files
------------

// File: rtl/paddle_cmd_queue.sv
// rtl/paddle_cmd_queue.sv - frame-synchronous paddle command FIFO with clamp and optional slew
// Optional feature macro: PADDLE_SLEW_EN
module paddle_cmd_queue #(
  parameter int DEPTH    = 4,
  parameter int Y_MAX    = 420,
  parameter int Y_RESET  = 210,
  parameter int STEP_MAX = 8
) (
  input  logic        CLK,
  input  logic        resentinho,
  input  logic        CLK_EN,
  input  logic [31:0] dataa,
  input  logic        enable_game,
  input  logic        frame_start,
  output logic [8:0]  y_bar1,
  output logic [8:0]  y_bar2,
  output logic        refresh_bar1,
  output logic        refresh_bar2,
  output logic [31:0] status
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, SLEW} state_t;

  state_t        state;
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level, level_nx;
  logic [7:0]    drop_cnt;
  logic          en_q, armed;
  logic [8:0]    t1, t2, clamped, nxt1, nxt2;
  logic [9:0]    head;
  logic          push_req, push_ok, pop, drop, full, pending;
  logic          unused_bits;

  assign unused_bits = &{1'b0, dataa[31:10]};

  // armed stays low until CLK_EN is seen low, so a level held through reset is not a command
  assign push_req = CLK_EN & ~en_q & armed;
  assign full     = (level == LW'(DEPTH));
  assign pop      = (state == DRAIN) && (level != '0) && enable_game;
  assign push_ok  = push_req && enable_game && (!full || pop);
  assign drop     = push_req && enable_game && !push_ok;
  assign clamped  = (dataa[8:0] > 9'(Y_MAX)) ? 9'(Y_MAX) : dataa[8:0];
  assign head     = mem[rd_ptr];
  assign status   = {16'd0, drop_cnt, 8'(level)};

`ifdef PADDLE_SLEW_EN
  localparam logic signed [9:0] STEP = 10'(STEP_MAX);

  function automatic logic [8:0] step_to(input logic [8:0] y, input logic [8:0] t);
    logic signed [9:0] d;
    d = $signed({1'b0, t}) - $signed({1'b0, y});
    if (d > STEP)       step_to = y + 9'(STEP_MAX);
    else if (d < -STEP) step_to = y - 9'(STEP_MAX);
    else                step_to = t;
  endfunction

  assign pending = (y_bar1 != t1) || (y_bar2 != t2);
`else
  function automatic logic [8:0] step_to(input logic [8:0] y, input logic [8:0] t);
    step_to = (y == t) ? y : t;
  endfunction

  assign pending = 1'b0;
`endif

  assign nxt1 = step_to(y_bar1, t1);
  assign nxt2 = step_to(y_bar2, t2);

  always_comb begin
    level_nx = level;
    if (!enable_game) begin
      level_nx = '0;
    end else begin
      if (push_ok) level_nx = level_nx + LW'(1);
      if (pop)     level_nx = level_nx - LW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= {dataa[9], clamped};
  end

  always_ff @(posedge CLK or negedge resentinho) begin
    if (!resentinho) begin
      en_q     <= 1'b0;
      armed    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= 8'd0;
    end else begin
      en_q  <= CLK_EN;
      level <= level_nx;
      if (!CLK_EN) armed <= 1'b1;
      if (!enable_game) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge resentinho) begin
    if (!resentinho) begin
      state        <= IDLE;
      t1           <= 9'(Y_RESET);
      t2           <= 9'(Y_RESET);
      y_bar1       <= 9'(Y_RESET);
      y_bar2       <= 9'(Y_RESET);
      refresh_bar1 <= 1'b0;
      refresh_bar2 <= 1'b0;
    end else begin
      refresh_bar1 <= 1'b0;
      refresh_bar2 <= 1'b0;
      case (state)
        IDLE: if (level_nx != '0 || pending) state <= WAIT;
        WAIT: begin
          if (frame_start && (level != '0 || pending)) state <= DRAIN;
          else if (level_nx == '0 && !pending)         state <= IDLE;
        end
        DRAIN: begin
          // later entries overwrite earlier ones, so the last command per bar wins
          if (pop) begin
            if (head[9]) t1 <= head[8:0];
            else         t2 <= head[8:0];
          end
          if (!enable_game || level_nx == '0) state <= SLEW;
        end
        SLEW: begin
          if (nxt1 != y_bar1) begin
            y_bar1       <= nxt1;
            refresh_bar1 <= 1'b1;
          end
          if (nxt2 != y_bar2) begin
            y_bar2       <= nxt2;
            refresh_bar2 <= 1'b1;
          end
          state <= (level_nx != '0) ? WAIT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_cmd_queue.sv
// tb/tb_paddle_cmd_queue.sv - scoreboard bench for paddle_cmd_queue against a queue-based model
module tb_paddle_cmd_queue;

  localparam int DEPTH = 4;
  localparam int Y_MAX = 420;
  localparam int Y_RESET = 210;
  localparam int STEP_MAX = 8;

  logic        CLK = 1'b0;
  logic        resentinho, CLK_EN, enable_game, frame_start;
  logic [31:0] dataa;
  logic [8:0]  y_bar1, y_bar2;
  logic        refresh_bar1, refresh_bar2;
  logic [31:0] status;

  paddle_cmd_queue #(.DEPTH(DEPTH), .Y_MAX(Y_MAX), .Y_RESET(Y_RESET), .STEP_MAX(STEP_MAX)) dut (
    .CLK(CLK), .resentinho(resentinho), .CLK_EN(CLK_EN), .dataa(dataa),
    .enable_game(enable_game), .frame_start(frame_start),
    .y_bar1(y_bar1), .y_bar2(y_bar2), .refresh_bar1(refresh_bar1),
    .refresh_bar2(refresh_bar2), .status(status)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit r1;
    bit r2;
    int y1;
    int y2;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int   m_q[$];
  int   m_drops, m_t1, m_t2, m_y1, m_y2;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every refresh pulse must match the next expected frame update
  always @(negedge CLK) begin
    if (refresh_bar1 || refresh_bar2) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_refresh: got r1=%0d r2=%0d y1=%0d y2=%0d at cycle %0d, none expected",
                 refresh_bar1, refresh_bar2, y_bar1, y_bar2, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (refresh_bar1 !== e.r1 || refresh_bar2 !== e.r2 || int'(y_bar1) != e.y1 ||
            int'(y_bar2) != e.y2 || cyc != e.cyc) begin
          errors++;
          $display("FAIL refresh: got r1=%0d r2=%0d y1=%0d y2=%0d cyc=%0d expected r1=%0d r2=%0d y1=%0d y2=%0d cyc=%0d",
                   refresh_bar1, refresh_bar2, y_bar1, y_bar2, cyc, e.r1, e.r2, e.y1, e.y2, e.cyc);
        end
      end
    end
  end

  function automatic int m_step(input int y, input int t);
`ifdef PADDLE_SLEW_EN
    if (t - y > STEP_MAX) return y + STEP_MAX;
    if (y - t > STEP_MAX) return y - STEP_MAX;
`endif
    return t;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_drops = 0;
    m_t1 = Y_RESET; m_t2 = Y_RESET;
    m_y1 = Y_RESET; m_y2 = Y_RESET;
  endtask

  task automatic send_cmd(input bit bar, input int y);
    @(posedge CLK); #1;
    dataa  = {22'($urandom), bar, 9'(y)};
    CLK_EN = 1'b1;
    @(posedge CLK); #1;
    CLK_EN = 1'b0;
    if (enable_game) begin
      if (m_q.size() < DEPTH) m_q.push_back(bar ? (1000 + (y > Y_MAX ? Y_MAX : y)) : (y > Y_MAX ? Y_MAX : y));
      else if (m_drops < 255) m_drops++;
    end
  endtask

  task automatic check_status(input string name);
    chk(name, int'(status), (m_drops << 8) | m_q.size());
  endtask

  task automatic do_frame();
    int  k, f, n1, n2;
    bit  pend;
    exp_t e;
    k = m_q.size();
    pend = (k != 0);
`ifdef PADDLE_SLEW_EN
    pend = pend || (m_y1 != m_t1) || (m_y2 != m_t2);
`endif
    @(posedge CLK); #1;
    frame_start = 1'b1;
    f = cyc;
    @(posedge CLK); #1;
    frame_start = 1'b0;
    if (pend) begin
      foreach (m_q[i]) begin
        if (m_q[i] >= 1000) m_t1 = m_q[i] - 1000;
        else                m_t2 = m_q[i];
      end
      m_q.delete();
      n1 = m_step(m_y1, m_t1);
      n2 = m_step(m_y2, m_t2);
      if (n1 != m_y1 || n2 != m_y2) begin
        e.r1 = (n1 != m_y1); e.r2 = (n2 != m_y2);
        e.y1 = n1; e.y2 = n2;
        e.cyc = f + (k > 0 ? k : 1) + 2;
        sb.push_back(e);
      end
      m_y1 = n1; m_y2 = n2;
    end
    repeat (DEPTH + 8) @(posedge CLK);
    #1;
  endtask

  initial begin
    resentinho = 1'b0; CLK_EN = 1'b1; enable_game = 1'b1; frame_start = 1'b0; dataa = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_y1", y_bar1, Y_RESET);
    chk("reset_y2", y_bar2, Y_RESET);
    chk("reset_refresh", {refresh_bar1, refresh_bar2}, 0);
    chk("reset_status", status, 0);
    resentinho = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    chk("held_clk_en_no_push", status, 0);
    CLK_EN = 1'b0;

    // single command, then frame 10 cycles later
    send_cmd(1'b1, 100);
    check_status("single_status");
    repeat (8) @(posedge CLK);
    do_frame();
    chk("single_y1", y_bar1, m_y1);
    chk("single_y2", y_bar2, m_y2);

    // clamp and coalesce on bar 2
    send_cmd(1'b0, 500);
    send_cmd(1'b0, 300);
    do_frame();
    send_cmd(1'b0, 511);
    do_frame();
    chk("clamp_y2", y_bar2, m_y2);

    // overflow: DEPTH accepted, rest dropped
    repeat (6) send_cmd(1'(($urandom)), $urandom_range(0, 511));
    check_status("overflow_status");
    do_frame();

    for (int r = 0; r < 20; r++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int c = 0; c < n; c++) send_cmd(1'($urandom), $urandom_range(0, 511));
      check_status("random_status");
      do_frame();
    end
    chk("random_y1", y_bar1, m_y1);
    chk("random_y2", y_bar2, m_y2);

    // game disable discards queue and ignores requests
    repeat (3) send_cmd(1'($urandom), $urandom_range(0, 511));
    check_status("pre_disable_status");
    @(posedge CLK); #1;
    enable_game = 1'b0;
    @(posedge CLK); #1;
    m_q.delete();
    check_status("disable_level");
    send_cmd(1'b1, 7);
    check_status("disable_no_count");
    enable_game = 1'b1;
    repeat (4) @(posedge CLK);

    // drop counter saturation
    repeat (DEPTH) send_cmd(1'($urandom), $urandom_range(0, 511));
    repeat (300) send_cmd(1'($urandom), $urandom_range(0, 511));
    check_status("drop_saturate");
    do_frame();

    // asynchronous reset mid-operation
    send_cmd(1'b1, 50);
    send_cmd(1'b0, 60);
    #2;
    resentinho = 1'b0;
    #1;
    chk("midreset_status", status, 0);
    chk("midreset_y1", y_bar1, Y_RESET);
    chk("midreset_y2", y_bar2, Y_RESET);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    resentinho = 1'b1;
    repeat (2) @(posedge CLK);

    send_cmd(1'b1, 0);
    repeat (28) do_frame();
    chk("final_y1", y_bar1, m_y1);
    chk("final_y2", y_bar2, m_y2);
`ifdef PADDLE_SLEW_EN
    chk("slew_reached_zero", y_bar1, 0);
`endif
    chk("pending_refresh", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
